// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared UART definitions. Provides the frame width, the
//                default baud divisor and the receiver state encoding.
//                No ports; imported by uart_rx.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

    // Payload bits per frame (8N1)
    localparam int DATA_BITS        = 8;

    // Default clock cycles per bit period
    localparam int CLKS_PER_BIT_DEF = 104;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } rx_state_e;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchroniser for a single asynchronous input.
//                Both flops reset to 1 so an idle-high line does not look
//                like an edge when reset is released.
//  Ports       : clk_i    system clock
//                rst_ni   asynchronous active-low reset
//                async_i  asynchronous input
//                sync_o   synchronised output (two cycles of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with a one-entry holding register and a
//                valid/ready handshake. Reports framing errors and overruns
//                as single-cycle pulses.
//  Ports       : clk_i         system clock, rising edge
//                rst_ni        asynchronous active-low reset
//                rx_i          serial line (asynchronous, idles high)
//                data_o        received byte (holding register)
//                data_valid_o  holding register full
//                data_ready_i  consumer accepts when valid && ready
//                busy_o        frame in progress
//                frame_err_o   1-cycle pulse: stop bit sampled low
//                overrun_o     1-cycle pulse: byte dropped, holding reg full
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 busy_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] c_CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Line synchroniser
    // ------------------------------------------------------------------
    logic w_rx_s;

    uart_rx_sync u_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (rx_i),
        .sync_o  (w_rx_s)
    );

    // ------------------------------------------------------------------
    // Frame FSM, baud counter, bit index and shift register
    // ------------------------------------------------------------------
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic [IW-1:0]        idx_q,   idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 w_deliver;
    logic                 w_ferr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        w_deliver = 1'b0;
        w_ferr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!w_rx_s) begin
                    state_d = ST_START;
                end
            end

            // Re-check the start bit at its midpoint; a high level here is
            // a line glitch and is dropped silently.
            ST_START: begin
                if (cnt_q == c_CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end

            // Counting a full bit period from mid-start lands on mid-bit.
            // LSB arrives first, so shift in from the top.
            ST_DATA: begin
                if (cnt_q == c_CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {w_rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == c_IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end

            // Returning to IDLE at mid-stop lets a back-to-back start edge
            // be caught at the end of this stop bit.
            ST_STOP: begin
                if (cnt_q == c_CNT_FULL) begin
                    cnt_d = '0;
                    if (w_rx_s) begin
                        w_deliver = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        w_ferr  = 1'b1;
                        state_d = ST_WAIT_HI;
                    end
                end
            end

            // A break or stuck-low line must not be seen as new start bits.
            ST_WAIT_HI: begin
                cnt_d = '0;
                if (w_rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register and status flags
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= w_ferr;
            overrun_q   <= 1'b0;
            if (w_deliver) begin
                // Free slot, or the old byte leaves this same cycle.
                if (!valid_q || data_ready_i) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && data_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Expected bytes go into a
//                queue as frames are driven; a monitor pops and compares on
//                every accepted byte. Table-driven frames plus hand-written
//                sequences for glitch, break, overrun, reset and
//                back-to-back cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CPB = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       ferr;
    logic       ovr;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx),
        .data_o       (data),
        .data_valid_o (valid),
        .data_ready_i (ready),
        .busy_o       (busy),
        .frame_err_o  (ferr),
        .overrun_o    (ovr)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         acc_cnt  = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         vhi_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) vhi_cnt++;
            if (ferr)  ferr_cnt++;
            if (ovr)   ovr_cnt++;
            if (ferr || ovr) check("flags_exclusive", {31'b0, ferr & ovr}, 32'd0);
            if (valid && ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", data);
                end else begin
                    check("rx_byte", {24'b0, data}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    // Hold rx at b for n cycles; always returns 1 time unit after a posedge.
    task automatic set_rx(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        set_rx(1'b0, CPB);
        for (int i = 0; i < 8; i++) set_rx(d[i], CPB);
        set_rx(stop, CPB);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_acc;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, f0, o0, v0;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h81, 1'b1, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 0, 1};
        vecs[5] = '{8'hC3, 1'b1, 1, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  {24'b0, data}, 32'h00);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_busy",  {31'b0, busy},  32'd0);
        check("reset_ferr",  {31'b0, ferr},  32'd0);
        check("reset_ovr",   {31'b0, ovr},   32'd0);
        rst_n = 1'b1;
        set_rx(1'b1, 2 * CPB);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            a0 = acc_cnt; f0 = ferr_cnt; v0 = vhi_cnt;
            if (vecs[i].exp_acc != 0) exp_q.push_back(vecs[i].d);
            send_frame(vecs[i].d, vecs[i].stop);
            set_rx(1'b1, 2 * CPB);
            check("vec_accepts",   acc_cnt - a0,  vecs[i].exp_acc);
            check("vec_valid_cyc", vhi_cnt - v0,  vecs[i].exp_acc);
            check("vec_frame_err", ferr_cnt - f0, vecs[i].exp_ferr);
            check("vec_busy_idle", {31'b0, busy}, 32'd0);
        end

        // Short low glitch: no byte, no error
        a0 = acc_cnt; f0 = ferr_cnt;
        set_rx(1'b0, 2);
        set_rx(1'b1, 1);
        check("glitch_busy_hi", {31'b0, busy}, 32'd1);
        set_rx(1'b1, 6);
        check("glitch_busy_lo", {31'b0, busy}, 32'd0);
        check("glitch_no_byte", acc_cnt - a0,  32'd0);
        check("glitch_no_ferr", ferr_cnt - f0, 32'd0);

        // Bad stop bit followed by a long break
        a0 = acc_cnt; f0 = ferr_cnt; v0 = vhi_cnt;
        send_frame(8'h3C, 1'b0);
        set_rx(1'b0, 20 * CPB);
        check("break_one_ferr",  ferr_cnt - f0, 32'd1);
        check("break_no_valid",  vhi_cnt - v0,  32'd0);
        check("break_wait_busy", {31'b0, busy}, 32'd1);
        set_rx(1'b1, 2 * CPB);
        check("break_recovered", {31'b0, busy}, 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        set_rx(1'b1, 2 * CPB);
        check("break_then_byte", acc_cnt - a0, 32'd1);

        // Overrun while consumer stalls
        ready = 1'b0;
        a0 = acc_cnt; o0 = ovr_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        set_rx(1'b1, 2 * CPB);
        send_frame(8'h22, 1'b1);
        set_rx(1'b1, 2 * CPB);
        check("ovr_pulse",     ovr_cnt - o0,  32'd1);
        check("ovr_no_ferr",   ferr_cnt - f0, 32'd0);
        check("ovr_keep_data", {24'b0, data}, 32'h11);
        check("ovr_valid",     {31'b0, valid}, 32'd1);
        check("ovr_no_accept", acc_cnt - a0,  32'd0);
        ready = 1'b1;
        set_rx(1'b1, 2);
        check("ovr_accept",    acc_cnt - a0,  32'd1);
        check("ovr_valid_clr", {31'b0, valid}, 32'd0);

        // Reset in the middle of a frame
        set_rx(1'b0, CPB);
        for (int i = 0; i < 4; i++) set_rx(1'(8'h5A >> i), CPB);
        set_rx(1'b1, 3);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data",  {24'b0, data},  32'h00);
        check("mid_rst_valid", {31'b0, valid}, 32'd0);
        check("mid_rst_busy",  {31'b0, busy},  32'd0);
        check("mid_rst_ferr",  {31'b0, ferr},  32'd0);
        check("mid_rst_ovr",   {31'b0, ovr},   32'd0);
        set_rx(1'b1, 3);
        rst_n = 1'b1;
        set_rx(1'b1, 2 * CPB);
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        set_rx(1'b1, 2 * CPB);
        check("post_rst_byte", acc_cnt - a0,  32'd1);
        check("post_rst_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

        // Back-to-back frames with no idle gap
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        set_rx(1'b1, 2 * CPB);
        check("b2b_two_bytes", acc_cnt - a0, 32'd2);
        check("b2b_no_errs",   (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
